// File: rtl/sobel_mag_pipe.sv
// sobel_mag_pipe: 4-stage pipelined Sobel gradient-magnitude core.
// One 3x3 window in, one saturated magnitude out per cycle over valid/ready,
// with a per-beat magnitude mode and a running per-frame maximum.
// Optional feature macro: SOBEL_THRESH_EN (enables the out_edge comparator).
module sobel_mag_pipe #(
  parameter int PIX_W  = 8,
  parameter int THRESH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sof,
  input  logic [1:0]         in_mode,
  input  logic [9*PIX_W-1:0] in_win,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIX_W-1:0]   out_mag,
  output logic               out_sof,
  output logic               out_edge,
  output logic [PIX_W-1:0]   frame_max
);

  localparam int GW = PIX_W + 3;      // signed gradient width
  localparam int MW = PIX_W + 1;      // working magnitude width before saturation
  localparam int RW = 2 * PIX_W + 2;  // radicand width, rounded up to an even bit count

  localparam logic [PIX_W-1:0] M    = '1;
  localparam logic [GW-1:0]    M_GW = {{(GW - PIX_W){1'b0}}, M};

  // Stall-all handshake: every stage moves together when the output slot frees up
  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv & !rst;

  // Zero-extend each pixel into the signed gradient width so differences never wrap
  logic signed [GW-1:0] pix_ext [9];
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_ext
      assign pix_ext[gi] = $signed({{(GW - PIX_W){1'b0}}, in_win[gi*PIX_W +: PIX_W]});
    end
  endgenerate

  // The centre pixel has a zero weight in both kernels
  logic unused_p4;
  assign unused_p4 = ^pix_ext[4];

  logic signed [GW-1:0] gx_next, gy_next;
  assign gx_next = (pix_ext[2] - pix_ext[0]) + ((pix_ext[5] - pix_ext[3]) <<< 1) + (pix_ext[8] - pix_ext[6]);
  assign gy_next = (pix_ext[0] - pix_ext[6]) + ((pix_ext[1] - pix_ext[7]) <<< 1) + (pix_ext[2] - pix_ext[8]);

  // Absolute value of each gradient, clamped to the pixel range
  logic [GW-1:0]    abs_gx, abs_gy;
  logic [PIX_W-1:0] ax_next, ay_next;
  logic signed [GW-1:0] s1_gx_reg, s1_gy_reg;
  assign abs_gx  = s1_gx_reg[GW-1] ? -s1_gx_reg : s1_gx_reg;
  assign abs_gy  = s1_gy_reg[GW-1] ? -s1_gy_reg : s1_gy_reg;
  assign ax_next = (abs_gx > M_GW) ? M : abs_gx[PIX_W-1:0];
  assign ay_next = (abs_gy > M_GW) ? M : abs_gy[PIX_W-1:0];

  // Unrolled restoring square root: one result bit per iteration, MSB first
  function automatic logic [MW-1:0] isqrt(input logic [RW-1:0] rad);
    logic [RW-1:0] rem, root, bit_v, trial;
    rem   = rad;
    root  = '0;
    bit_v = {{(RW - 1){1'b0}}, 1'b1} << (RW - 2);
    for (int i = 0; i < MW; i++) begin
      trial = root + bit_v;
      if (rem >= trial) begin
        rem  = rem - trial;
        root = (root >> 1) + bit_v;
      end else begin
        root = root >> 1;
      end
      bit_v = bit_v >> 2;
    end
    return root[MW-1:0];
  endfunction

  logic [PIX_W-1:0] s2_ax_reg, s2_ay_reg;
  logic [1:0]       s2_mode_reg;
  logic [PIX_W-1:0] max_a, min_a;
  logic [RW-1:0]    rad;
  logic [MW-1:0]    mag_wide;
  logic [PIX_W-1:0] mag_sat;

  // Mode-selected magnitude at PIX_W+1 bits, then saturated to the pixel range
  always_comb begin
    max_a    = (s2_ax_reg >= s2_ay_reg) ? s2_ax_reg : s2_ay_reg;
    min_a    = (s2_ax_reg >= s2_ay_reg) ? s2_ay_reg : s2_ax_reg;
    rad      = RW'(s2_ax_reg) * RW'(s2_ax_reg) + RW'(s2_ay_reg) * RW'(s2_ay_reg);
    mag_wide = {1'b0, s2_ax_reg} + {1'b0, s2_ay_reg};
    case (s2_mode_reg)
      2'd1:    mag_wide = {1'b0, max_a} + {2'b00, min_a[PIX_W-1:1]};
      2'd2:    mag_wide = isqrt(rad);
      default: mag_wide = {1'b0, s2_ax_reg} + {1'b0, s2_ay_reg};
    endcase
    mag_sat = mag_wide[PIX_W] ? M : mag_wide[PIX_W-1:0];
  end

  logic             s1_valid_reg, s2_valid_reg, s3_valid_reg, out_valid_reg;
  logic             s1_sof_reg, s2_sof_reg, s3_sof_reg, out_sof_reg;
  logic [1:0]       s1_mode_reg;
  logic [PIX_W-1:0] s3_mag_reg, out_mag_reg;

  // Pipeline registers S1..S4; all stages freeze together on a downstream stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_sof_reg    <= 1'b0;
      s1_mode_reg   <= 2'd0;
      s1_gx_reg     <= '0;
      s1_gy_reg     <= '0;
      s2_valid_reg  <= 1'b0;
      s2_sof_reg    <= 1'b0;
      s2_mode_reg   <= 2'd0;
      s2_ax_reg     <= '0;
      s2_ay_reg     <= '0;
      s3_valid_reg  <= 1'b0;
      s3_sof_reg    <= 1'b0;
      s3_mag_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_sof_reg   <= 1'b0;
      out_mag_reg   <= '0;
    end else if (adv) begin
      s1_valid_reg  <= in_valid & in_ready;
      s1_sof_reg    <= in_sof;
      s1_mode_reg   <= in_mode;
      s1_gx_reg     <= gx_next;
      s1_gy_reg     <= gy_next;
      s2_valid_reg  <= s1_valid_reg;
      s2_sof_reg    <= s1_sof_reg;
      s2_mode_reg   <= s1_mode_reg;
      s2_ax_reg     <= ax_next;
      s2_ay_reg     <= ay_next;
      s3_valid_reg  <= s2_valid_reg;
      s3_sof_reg    <= s2_sof_reg;
      s3_mag_reg    <= mag_sat;
      out_valid_reg <= s3_valid_reg;
      out_sof_reg   <= s3_sof_reg;
      out_mag_reg   <= s3_mag_reg;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_sof   = out_sof_reg;
  assign out_mag   = out_mag_reg;

`ifdef SOBEL_THRESH_EN
  localparam logic [31:0] THRESH_U = THRESH;
  logic out_edge_reg;

  // Edge flag registered alongside out_mag so it holds through stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_edge_reg <= 1'b0;
    end else if (adv) begin
      out_edge_reg <= (32'(s3_mag_reg) >= THRESH_U);
    end
  end

  assign out_edge = out_edge_reg;
`else
  // Threshold only matters when the comparator is built
  logic unused_thresh;
  assign unused_thresh = (THRESH != 0);
  assign out_edge      = 1'b0;
`endif

  logic [PIX_W-1:0] frame_max_reg;

  // Running frame maximum, updated only when an output beat is actually taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_max_reg <= '0;
    end else if (out_valid_reg & out_ready) begin
      if (out_sof_reg) begin
        frame_max_reg <= out_mag_reg;
      end else if (out_mag_reg > frame_max_reg) begin
        frame_max_reg <= out_mag_reg;
      end
    end
  end

  assign frame_max = frame_max_reg;

endmodule

// File: tb/tb_sobel_mag_pipe.sv
// Self-checking bench for sobel_mag_pipe (PIX_W = 8, THRESH = 64).
module tb_sobel_mag_pipe;
  localparam int PW = 8;
  localparam int TH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_sof;
  logic [1:0]    in_mode;
  logic [9*PW-1:0] in_win;
  logic          out_valid, out_ready;
  logic [PW-1:0] out_mag;
  logic          out_sof, out_edge;
  logic [PW-1:0] frame_max;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int   mag;
    logic sof;
    logic edg;
  } exp_t;
  exp_t sb[$];

  sobel_mag_pipe #(.PIX_W(PW), .THRESH(TH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_mode(in_mode), .in_win(in_win),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mag(out_mag), .out_sof(out_sof), .out_edge(out_edge),
    .frame_max(frame_max)
  );

  always #5 clk = ~clk;

  // Reference magnitude from plain integer arithmetic
  function automatic int model_mag(input logic [9*PW-1:0] w, input logic [1:0] m);
    int p[9];
    int gx, gy, ax, ay, mx, mn, s, r;
    for (int k = 0; k < 9; k++) p[k] = int'(w[k*PW +: PW]);
    gx = (p[2] - p[0]) + 2 * (p[5] - p[3]) + (p[8] - p[6]);
    gy = (p[0] - p[6]) + 2 * (p[1] - p[7]) + (p[2] - p[8]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    if (ax > 255) ax = 255;
    if (ay > 255) ay = 255;
    mx = (ax > ay) ? ax : ay;
    mn = (ax > ay) ? ay : ax;
    case (m)
      2'd1: r = mx + mn / 2;
      2'd2: begin
        s = ax * ax + ay * ay;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
      end
      default: r = ax + ay;
    endcase
    if (r > 255) r = 255;
    return r;
  endfunction

  function automatic logic model_edge(input int mag);
`ifdef SOBEL_THRESH_EN
    return (mag >= TH);
`else
    return 1'b0 && (mag >= 0);
`endif
  endfunction

  // One clock cycle: drive inputs, sample handshakes #1 later, push accepted beats
  task automatic drive_cycle(input logic v, input logic [9*PW-1:0] w, input logic [1:0] m,
                             input logic s, input logic r,
                             output logic acc, output logic took, output logic [PW-1:0] mag,
                             output logic osof, output logic oedg);
    exp_t e;
    in_valid = v; in_win = w; in_mode = m; in_sof = s; out_ready = r;
    #1;
    acc  = in_valid & in_ready;
    took = out_valid & out_ready;
    mag  = out_mag;
    osof = out_sof;
    oedg = out_edge;
    if (acc) begin
      e.mag = model_mag(w, m);
      e.sof = s;
      e.edg = model_edge(e.mag);
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_mode = 2'd0; in_win = '0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    rst = 1'b0;
    #1;
    total++;
    if ({out_valid, out_mag, out_sof, out_edge, frame_max} !== {1'b0, 8'd0, 1'b0, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL reset_state got v=%0b mag=%0d sof=%0b edge=%0b fmax=%0d exp all 0",
               out_valid, out_mag, out_sof, out_edge, frame_max);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%0b exp=1", in_ready); end
    @(negedge clk);
  endtask

  // T1/T2: full-scale steps in both directions, modes 0..2, with latency check
  task automatic test_step();
    logic [9*PW-1:0] wins[2];
    logic acc, took, osof, oedg;
    logic [PW-1:0] mag;
    exp_t e;
    int lat;
    wins[0] = {8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0};
    wins[1] = {8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255};
    for (int w = 0; w < 2; w++) begin
      for (int m = 0; m < 3; m++) begin
        drive_cycle(1'b1, wins[w], 2'(m), 1'b0, 1'b1, acc, took, mag, osof, oedg);
        total++;
        if (acc !== 1'b1) begin bad++; $display("FAIL step_accept w=%0d m=%0d got=%0b exp=1", w, m, acc); end
        lat = -1;
        for (int n = 1; n <= 10 && lat < 0; n++) begin
          drive_cycle(1'b0, '0, 2'd0, 1'b0, 1'b1, acc, took, mag, osof, oedg);
          if (took) begin
            lat = n;
            total++;
            if (mag !== 8'd255) begin bad++; $display("FAIL step_mag w=%0d m=%0d got=%0d exp=255", w, m, mag); end
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL step_sb_empty w=%0d m=%0d", w, m); end
            else begin
              e = sb.pop_front();
              if ({mag, osof, oedg} !== {8'(e.mag), e.sof, e.edg}) begin
                bad++;
                $display("FAIL step_sb got=%0d/%0b/%0b exp=%0d/%0b/%0b", mag, osof, oedg, e.mag, e.sof, e.edg);
              end
            end
          end
        end
        total++;
        if (lat != 4) begin bad++; $display("FAIL step_latency w=%0d m=%0d got=%0d exp=4", w, m, lat); end
      end
    end
  endtask

  // T3: gx=30, gy=40 in all four modes, back to back
  task automatic test_modes();
    logic [9*PW-1:0] w;
    logic acc, took, osof, oedg;
    logic [PW-1:0] mag;
    exp_t e;
    int exp_mag[4];
    logic exp_edg[4];
    int outs;
    exp_mag = '{70, 55, 50, 70};
`ifdef SOBEL_THRESH_EN
    exp_edg = '{1'b1, 1'b0, 1'b0, 1'b1};
`else
    exp_edg = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    w = {8'd0, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd10, 8'd15, 8'd0};
    outs = 0;
    for (int i = 0; i < 16 && outs < 4; i++) begin
      drive_cycle(i < 4, w, 2'(i), 1'b0, 1'b1, acc, took, mag, osof, oedg);
      if (took) begin
        total++;
        if ({mag, oedg} !== {8'(exp_mag[outs]), exp_edg[outs]}) begin
          bad++;
          $display("FAIL mode_mag m=%0d got=%0d/%0b exp=%0d/%0b", outs, mag, oedg, exp_mag[outs], exp_edg[outs]);
        end
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL mode_sb_empty m=%0d", outs); end
        else begin
          e = sb.pop_front();
          if ({mag, osof, oedg} !== {8'(e.mag), e.sof, e.edg}) begin
            bad++;
            $display("FAIL mode_sb got=%0d/%0b/%0b exp=%0d/%0b/%0b", mag, osof, oedg, e.mag, e.sof, e.edg);
          end
        end
        outs++;
      end
    end
    total++;
    if (outs != 4) begin bad++; $display("FAIL mode_count got=%0d exp=4", outs); end
  endtask

  // T4: 8-beat stream with a 3-cycle output stall
  task automatic test_back_to_back();
    logic [9*PW-1:0] w;
    logic acc, took, osof, oedg;
    logic [PW-1:0] mag, stall_mag;
    exp_t e;
    int sent, outs, last_out;
    sent = 0; outs = 0; last_out = -1; stall_mag = '0;
    for (int i = 0; i < 40 && outs < 8; i++) begin
      for (int k = 0; k < 9; k++) w[k*PW +: PW] = 8'($urandom_range(0, 255));
      drive_cycle(sent < 8, w, 2'($urandom_range(0, 3)), 1'b0, !(i >= 5 && i <= 7),
                  acc, took, mag, osof, oedg);
      if (acc) sent++;
      if (i >= 5 && i <= 7) begin
        total++;
        if (acc !== 1'b0) begin bad++; $display("FAIL b2b_stall_ready cyc=%0d got=%0b exp=0", i, acc); end
        if (i == 5) stall_mag = mag;
        else begin
          total++;
          if (mag !== stall_mag) begin bad++; $display("FAIL b2b_stall_hold cyc=%0d got=%0d exp=%0d", i, mag, stall_mag); end
        end
      end
      if (took) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL b2b_extra_out cyc=%0d got=%0d", i, mag); end
        else begin
          e = sb.pop_front();
          if ({mag, osof, oedg} !== {8'(e.mag), e.sof, e.edg}) begin
            bad++;
            $display("FAIL b2b_out idx=%0d got=%0d/%0b/%0b exp=%0d/%0b/%0b", outs, mag, osof, oedg, e.mag, e.sof, e.edg);
          end
        end
        outs++;
        last_out = i;
      end
    end
    total++;
    if (outs != 8 || sb.size() != 0) begin bad++; $display("FAIL b2b_count got=%0d left=%0d exp=8/0", outs, sb.size()); end
    total++;
    if (last_out != 14) begin bad++; $display("FAIL b2b_last_cycle got=%0d exp=14", last_out); end
  endtask

  // T5: per-frame maximum across two frames, plus a stalled beat that must not count
  task automatic test_frame();
    logic [9*PW-1:0] w;
    logic acc, took, osof, oedg;
    logic [PW-1:0] mag;
    exp_t e;
    int p5[6], sofs[6], fmax[6];
    bit got;
    p5   = '{20, 100, 35, 5, 15, 125};
    sofs = '{1, 0, 0, 1, 0, 0};
    fmax = '{40, 200, 200, 10, 30, 250};
    for (int b = 0; b < 6; b++) begin
      w = '0;
      w[5*PW +: PW] = 8'(p5[b]);
      drive_cycle(1'b1, w, 2'd0, sofs[b] != 0, b != 5, acc, took, mag, osof, oedg);
      if (b == 5) begin
        for (int n = 0; n < 6; n++) drive_cycle(1'b0, '0, 2'd0, 1'b0, 1'b0, acc, took, mag, osof, oedg);
        total++;
        if ({out_valid, frame_max} !== {1'b1, 8'd30}) begin
          bad++;
          $display("FAIL frame_stall got v=%0b fmax=%0d exp v=1 fmax=30", out_valid, frame_max);
        end
      end
      got = 0;
      for (int n = 0; n < 10 && !got; n++) begin
        drive_cycle(1'b0, '0, 2'd0, 1'b0, 1'b1, acc, took, mag, osof, oedg);
        if (took) begin
          got = 1;
          total++;
          if (sb.size() == 0) begin bad++; $display("FAIL frame_sb_empty b=%0d", b); end
          else begin
            e = sb.pop_front();
            if ({mag, osof, oedg} !== {8'(e.mag), e.sof, e.edg}) begin
              bad++;
              $display("FAIL frame_out b=%0d got=%0d/%0b/%0b exp=%0d/%0b/%0b", b, mag, osof, oedg, e.mag, e.sof, e.edg);
            end
          end
        end
      end
      total++;
      if (!got || frame_max !== 8'(fmax[b])) begin
        bad++;
        $display("FAIL frame_max b=%0d got=%0d exp=%0d", b, frame_max, fmax[b]);
      end
    end
  endtask

  // T6: reset with three beats in flight
  task automatic test_reset_flight();
    logic [9*PW-1:0] w;
    logic acc, took, osof, oedg;
    logic [PW-1:0] mag;
    int stale;
    w = {8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0};
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, w, 2'd0, 1'b0, 1'b1, acc, took, mag, osof, oedg);
    for (int i = 0; i < 2; i++) drive_cycle(1'b0, '0, 2'd0, 1'b0, 1'b0, acc, took, mag, osof, oedg);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL rstf_pre_valid got=%0b exp=1", out_valid); end
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, out_mag, frame_max, in_ready} !== {1'b0, 8'd0, 8'd0, 1'b0}) begin
      bad++;
      $display("FAIL rstf_clear got v=%0b mag=%0d fmax=%0d rdy=%0b exp 0/0/0/0", out_valid, out_mag, frame_max, in_ready);
    end
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, '0, 2'd0, 1'b0, 1'b1, acc, took, mag, osof, oedg);
      if (took) stale++;
    end
    total++;
    if (stale != 0) begin bad++; $display("FAIL rstf_stale got=%0d exp=0", stale); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_modes();
    test_back_to_back();
    test_frame();
    test_reset_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case anything wedges
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
